// File: rtl/lpddr5_chk_pkg.sv
// Shared types for the LPDDR5 command checker: command decode, FSM states, flag positions.
package lpddr5_chk_pkg;

    typedef enum logic [3:0] {
        CMD_NONE, CMD_ACT1, CMD_RD16, CMD_WR16, CMD_MWR, CMD_REF, CMD_PDX,
        CMD_CAS_WR, CMD_CAS_RD, CMD_CAS_FS, CMD_CAS_OFF, CMD_OTHER
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WPEND, ST_RPEND, ST_FSWAIT, ST_FSSYNC, ST_PD
    } state_e;

    // CA slices are held CA0..CA6 from MSB to LSB, so codes read left to right.
    localparam logic [2:0] CA_ACT1_P = 3'b111;
    localparam logic [2:0] CA_RD16_P = 3'b100;
    localparam logic [2:0] CA_WR16_P = 3'b011;
    localparam logic [2:0] CA_MWR_P  = 3'b010;
    localparam logic [6:0] CA_REF     = 7'b0001110;
    localparam logic [6:0] CA_PDX     = 7'b0000001;
    localparam logic [6:0] CA_CAS_WR  = 7'b0011100;
    localparam logic [6:0] CA_CAS_RD  = 7'b0011010;
    localparam logic [6:0] CA_CAS_FS  = 7'b0011001;
    localparam logic [6:0] CA_CAS_OFF = 7'b0011111;

    localparam int NUM_FLAGS = 6;
    localparam int F_REFI    = 0;
    localparam int F_ACT_REF = 1;
    localparam int F_CAS_PR  = 2;
    localparam int F_CAS_FS  = 3;
    localparam int F_PD      = 4;
    localparam int F_WCK     = 5;

    function automatic cmd_e decode_cmd(input logic cs, input logic [6:0] ca);
        if (!cs)                      return CMD_NONE;
        if (ca[6:4] == CA_ACT1_P)     return CMD_ACT1;
        if (ca[6:4] == CA_RD16_P)     return CMD_RD16;
        if (ca[6:4] == CA_WR16_P)     return CMD_WR16;
        if (ca[6:4] == CA_MWR_P)      return CMD_MWR;
        if (ca == CA_REF)             return CMD_REF;
        if (ca == CA_PDX)             return CMD_PDX;
        if (ca == CA_CAS_WR)          return CMD_CAS_WR;
        if (ca == CA_CAS_RD)          return CMD_CAS_RD;
        if (ca == CA_CAS_FS)          return CMD_CAS_FS;
        if (ca == CA_CAS_OFF)         return CMD_CAS_OFF;
        return CMD_OTHER;
    endfunction

endpackage

// File: rtl/lpddr5_ch_checker.sv
// One channel: command decode, protocol FSM and timing counters.
// viol is combinational for the current edge; the top registers it.
module lpddr5_ch_checker
    import lpddr5_chk_pkg::*;
#(
    parameter int T_REFI    = 3900,
    parameter int T_ACT2REF = 6,
    parameter int T_CASWIN  = 8,
    parameter int T_CSLCK   = 5,
    parameter int T_WCK     = 6,
    parameter int CNT_W     = 16
) (
    input  logic                 ck_t,
    input  logic                 ddr_reset_n,
    input  logic                 cs,
    input  logic [6:0]           ca,
    input  logic                 wck_valid,
    output logic [NUM_FLAGS-1:0] viol
);

    localparam logic [CNT_W-1:0] REFI_LIM = CNT_W'(2 * T_REFI - 1);

    cmd_e             cmd;
    state_e           state, state_nxt;
    logic             is_wr, is_rw;
    logic             win_load, quiet_load;
    logic             v_pair, v_fs, v_pd;
    logic             refi_armed;
    logic [CNT_W-1:0] refi_cnt, act_cnt, wck_cnt, win_cnt, quiet_cnt;

    assign cmd   = decode_cmd(cs, ca);
    assign is_wr = (cmd == CMD_WR16) || (cmd == CMD_MWR);
    assign is_rw = is_wr || (cmd == CMD_RD16);

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) state <= ST_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        win_load   = 1'b0;
        quiet_load = 1'b0;
        v_pair     = 1'b0;
        v_fs       = 1'b0;
        v_pd       = 1'b0;
        case (state)
            ST_IDLE: begin
                case (cmd)
                    CMD_CAS_WR: state_nxt = ST_WPEND;
                    CMD_CAS_RD: state_nxt = ST_RPEND;
                    CMD_CAS_FS: begin state_nxt = ST_FSWAIT; win_load = 1'b1; end
                    CMD_PDX:    begin state_nxt = ST_PD; quiet_load = 1'b1; end
                    default: ;
                endcase
            end
            ST_WPEND: begin
                v_pair    = !is_wr;
                state_nxt = ST_IDLE;
            end
            ST_RPEND: begin
                v_pair    = (cmd != CMD_RD16);
                state_nxt = ST_IDLE;
            end
            ST_FSWAIT: begin
                // Expired window still enters sync mode so later RD/WR are not double-flagged.
                if (is_rw && win_cnt != '0)    state_nxt = ST_FSSYNC;
                else if (cmd == CMD_CAS_OFF)   state_nxt = ST_IDLE;
                else if (win_cnt == '0) begin
                    v_fs      = 1'b1;
                    state_nxt = ST_FSSYNC;
                end
            end
            ST_FSSYNC: begin
                if (cmd == CMD_CAS_OFF) state_nxt = ST_IDLE;
            end
            ST_PD: begin
                if (cmd != CMD_NONE) begin
                    if (quiet_cnt == '0 && cmd == CMD_PDX) state_nxt = ST_IDLE;
                    else                                   v_pd = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            refi_armed <= 1'b0;
            refi_cnt   <= '0;
            act_cnt    <= '0;
            wck_cnt    <= '0;
            win_cnt    <= '0;
            quiet_cnt  <= '0;
        end else begin
            if (cmd == CMD_REF) begin
                refi_armed <= 1'b1;
                refi_cnt   <= '0;
            end else if (refi_armed) begin
                if (refi_cnt == REFI_LIM)  refi_cnt <= '0;
                else if (refi_cnt != '1)   refi_cnt <= refi_cnt + 1'b1;
            end

            if (cmd == CMD_ACT1)        act_cnt <= CNT_W'(T_ACT2REF);
            else if (act_cnt != '0)     act_cnt <= act_cnt - 1'b1;

            if (is_wr)                  wck_cnt <= CNT_W'(T_WCK);
            else if (wck_cnt != '0)     wck_cnt <= wck_cnt - 1'b1;

            if (win_load)               win_cnt <= CNT_W'(T_CASWIN);
            else if (win_cnt != '0)     win_cnt <= win_cnt - 1'b1;

            if (quiet_load)             quiet_cnt <= CNT_W'(T_CSLCK);
            else if (quiet_cnt != '0)   quiet_cnt <= quiet_cnt - 1'b1;
        end
    end

    always_comb begin
        viol            = '0;
        viol[F_REFI]    = refi_armed && (refi_cnt == REFI_LIM) && (cmd != CMD_REF);
        viol[F_ACT_REF] = (cmd == CMD_REF) && (act_cnt != '0);
        viol[F_CAS_PR]  = v_pair;
        viol[F_CAS_FS]  = v_fs;
        viol[F_PD]      = v_pd;
        viol[F_WCK]     = (wck_cnt != '0) && !wck_valid;
    end

endmodule

// File: rtl/lpddr5_cmd_checker.sv
// LPDDR5 CA/CS protocol checker: per-channel checkers plus sticky flags,
// violation pulse and a saturating event counter.
module lpddr5_cmd_checker
    import lpddr5_chk_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int T_REFI    = 3900,
    parameter int T_ACT2REF = 6,
    parameter int T_CASWIN  = 8,
    parameter int T_CSLCK   = 5,
    parameter int T_WCK     = 6,
    parameter int CNT_W     = 16
) (
    input  logic                        ck_t,
    input  logic                        ddr_reset_n,
    input  logic [NUM_CH-1:0]           cs,
    input  logic [NUM_CH*7-1:0]         ca,
    input  logic [NUM_CH-1:0]           wck_valid,
    input  logic                        err_clr,
    output logic [NUM_CH*NUM_FLAGS-1:0] err_flags,
    output logic                        err_pulse,
    output logic [CNT_W-1:0]            err_count
);

    localparam int NV   = NUM_CH * NUM_FLAGS;
    localparam int PC_W = $clog2(NV + 1);

    logic [NUM_CH-1:0][NUM_FLAGS-1:0] viol;
    logic [NV-1:0]                    viol_flat;
    logic [PC_W-1:0]                  pc;
    logic [CNT_W-1:0]                 cnt_base;
    logic [CNT_W:0]                   cnt_sum;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        lpddr5_ch_checker #(
            .T_REFI(T_REFI), .T_ACT2REF(T_ACT2REF), .T_CASWIN(T_CASWIN),
            .T_CSLCK(T_CSLCK), .T_WCK(T_WCK), .CNT_W(CNT_W)
        ) u_ch (
            .ck_t        (ck_t),
            .ddr_reset_n (ddr_reset_n),
            .cs          (cs[g]),
            .ca          (ca[7*g +: 7]),
            .wck_valid   (wck_valid[g]),
            .viol        (viol[g])
        );
    end

    assign viol_flat = viol;

    always_comb begin
        pc = '0;
        for (int i = 0; i < NV; i++) pc = pc + PC_W'(viol_flat[i]);
    end

    // A clear in the same cycle as new events keeps the new events.
    assign cnt_base = err_clr ? '0 : err_count;
    assign cnt_sum  = {1'b0, cnt_base} + (CNT_W+1)'(pc);

    always_ff @(posedge ck_t or negedge ddr_reset_n) begin
        if (!ddr_reset_n) begin
            err_flags <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_flags <= (err_clr ? '0 : err_flags) | viol_flat;
            err_pulse <= |viol_flat;
            err_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_lpddr5_cmd_checker.sv
// Directed bench for lpddr5_cmd_checker: one task per protocol rule.
module tb_lpddr5_cmd_checker;

    localparam logic [6:0] C_ACT  = 7'b1110000;
    localparam logic [6:0] C_RD   = 7'b1000000;
    localparam logic [6:0] C_WR   = 7'b0110000;
    localparam logic [6:0] C_REF  = 7'b0001110;
    localparam logic [6:0] C_PDX  = 7'b0000001;
    localparam logic [6:0] C_CWR  = 7'b0011100;
    localparam logic [6:0] C_CRD  = 7'b0011010;
    localparam logic [6:0] C_CFS  = 7'b0011001;
    localparam logic [6:0] C_COFF = 7'b0011111;

    logic        ck_t = 1'b0;
    logic        ddr_reset_n;
    logic [1:0]  cs;
    logic [13:0] ca;
    logic [1:0]  wck_valid;
    logic        err_clr;
    logic [11:0] err_flags;
    logic        err_pulse;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    lpddr5_cmd_checker dut (
        .ck_t(ck_t), .ddr_reset_n(ddr_reset_n), .cs(cs), .ca(ca),
        .wck_valid(wck_valid), .err_clr(err_clr), .err_flags(err_flags),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 ck_t = ~ck_t;

    task automatic cyc();
        @(posedge ck_t);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic cmd(input int ch, input logic [6:0] code);
        cs[ch] = 1'b1;
        ca[ch*7 +: 7] = code;
        cyc();
        cs = '0;
        ca = '0;
    endtask

    task automatic do_reset();
        ddr_reset_n = 1'b0;
        cs = '0; ca = '0; err_clr = 1'b0; wck_valid = '1;
        idle(2);
        ddr_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL reset_flags got=%h want=%h", err_flags, 12'h000); end
        total++; if (err_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", err_pulse); end
        total++; if (err_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", err_count); end
    endtask

    task automatic test_refi();
        do_reset();
        idle(8);
        cmd(0, C_REF);
        idle(6999);
        cmd(0, C_REF);
        idle(100);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL refi_ok got=%h want=%h", err_flags, 12'h000); end
        do_reset();
        idle(8);
        cmd(0, C_REF);
        idle(7799);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL refi_early got=%h want=%h", err_flags, 12'h000); end
        cyc();
        total++; if (err_flags !== 12'h001) begin bad++; $display("FAIL refi_flag got=%h want=%h", err_flags, 12'h001); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL refi_pulse got=%b want=1", err_pulse); end
    endtask

    task automatic test_act_ref();
        do_reset();
        cmd(0, C_ACT);
        idle(5);
        cmd(0, C_REF);
        total++; if (err_flags !== 12'h002) begin bad++; $display("FAIL act_ref6 got=%h want=%h", err_flags, 12'h002); end
        total++; if (err_count !== 16'd1) begin bad++; $display("FAIL act_ref6_cnt got=%0d want=1", err_count); end
        do_reset();
        cmd(0, C_ACT);
        idle(6);
        cmd(0, C_REF);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL act_ref7 got=%h want=%h", err_flags, 12'h000); end
    endtask

    task automatic test_cas_pair();
        do_reset();
        cmd(0, C_CWR);
        cmd(0, C_RD);
        total++; if (err_flags !== 12'h004) begin bad++; $display("FAIL pair_wr_rd got=%h want=%h", err_flags, 12'h004); end
        do_reset();
        cmd(0, C_CRD);
        cmd(0, C_RD);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL pair_rd_rd got=%h want=%h", err_flags, 12'h000); end
        cmd(1, C_CRD);
        cmd(1, C_WR);
        total++; if (err_flags !== 12'h100) begin bad++; $display("FAIL pair_ch1 got=%h want=%h", err_flags, 12'h100); end
    endtask

    task automatic test_cas_fs();
        do_reset();
        cmd(0, C_CFS);
        idle(7);
        cmd(0, C_WR);
        for (int i = 0; i < 3; i++) cmd(0, C_RD);
        cmd(0, C_COFF);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL fs_in_window got=%h want=%h", err_flags, 12'h000); end
        do_reset();
        cmd(0, C_CFS);
        idle(8);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL fs_edge got=%h want=%h", err_flags, 12'h000); end
        cmd(0, C_WR);
        total++; if (err_flags !== 12'h008) begin bad++; $display("FAIL fs_late got=%h want=%h", err_flags, 12'h008); end
    endtask

    task automatic test_pd();
        do_reset();
        cmd(0, C_PDX);
        idle(2);
        cmd(0, C_REF);
        total++; if (err_flags !== 12'h010) begin bad++; $display("FAIL pd_early got=%h want=%h", err_flags, 12'h010); end
        do_reset();
        cmd(0, C_PDX);
        idle(5);
        cmd(0, C_PDX);
        cmd(0, C_REF);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL pd_exit got=%h want=%h", err_flags, 12'h000); end
    endtask

    task automatic test_wck();
        do_reset();
        cmd(0, C_WR);
        cyc();
        wck_valid = 2'b10;
        cyc();
        wck_valid = 2'b11;
        total++; if (err_flags !== 12'h020) begin bad++; $display("FAIL wck got=%h want=%h", err_flags, 12'h020); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cmd(0, C_CWR);
        cmd(0, C_RD);
        cs = 2'b11;
        ca = {C_CWR, C_CWR};
        cyc();
        cs = '0; ca = '0;
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        total++; if (err_flags !== 12'h104) begin bad++; $display("FAIL b2b_flags got=%h want=%h", err_flags, 12'h104); end
        total++; if (err_count !== 16'd2) begin bad++; $display("FAIL b2b_count got=%0d want=2", err_count); end
        total++; if (err_pulse !== 1'b1) begin bad++; $display("FAIL b2b_pulse got=%b want=1", err_pulse); end
        cyc();
        total++; if (err_pulse !== 1'b0 || err_flags !== 12'h104) begin bad++; $display("FAIL b2b_hold got=%b/%h want=0/104", err_pulse, err_flags); end
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        total++; if (err_flags !== 12'h000 || err_count !== 16'd0) begin bad++; $display("FAIL clear got=%h/%0d want=000/0", err_flags, err_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        cmd(1, C_CWR);
        cmd(1, C_RD);
        cmd(0, C_CFS);
        idle(3);
        #3;
        ddr_reset_n = 1'b0;
        #1;
        total++; if (err_flags !== 12'h000 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            bad++; $display("FAIL async_rst got=%h/%b/%0d want=000/0/0", err_flags, err_pulse, err_count);
        end
        cyc();
        ddr_reset_n = 1'b1;
        idle(20);
        total++; if (err_flags !== 12'h000) begin bad++; $display("FAIL post_rst got=%h want=%h", err_flags, 12'h000); end
    endtask

    initial begin
        ddr_reset_n = 1'b0;
        cs = '0; ca = '0; wck_valid = '1; err_clr = 1'b0;
        #2;
        test_reset();
        test_act_ref();
        test_cas_pair();
        test_cas_fs();
        test_pd();
        test_wck();
        test_back_to_back();
        test_async_reset();
        test_refi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
